fp_cvt_sched: RTL and testbench

FP_CVT_SCHED -- requirements
Module: fp_cvt_sched

---
 rtl/fp_cvt_pkg.sv | 23 ++
 rtl/fp_int_convert.sv | 80 ++++++++
 rtl/fp_cvt_sched.sv | 132 +++++++++++++
 tb/tb_fp_cvt_sched.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_cvt_pkg.sv
// Shared encodings for the FP-to-integer conversion scheduler.
// Output/input format codes, source IDs and result-register states.
package fp_cvt_pkg;

  localparam logic [1:0] FMT_S32 = 2'b00;
  localparam logic [1:0] FMT_U32 = 2'b01;
  localparam logic [1:0] FMT_S64 = 2'b10;
  localparam logic [1:0] FMT_U64 = 2'b11;

  localparam logic FP32 = 1'b0;
  localparam logic FP64 = 1'b1;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/fp_int_convert.sv
// FP_Int_Convert: combinational FP32/FP64 -> s32/u32/s64/u64, round to zero.
// Ports: in_data, in_fmt, in_output_fmt -> out_data, out_flg_NV.
module FP_Int_Convert
  import fp_cvt_pkg::*;
(
  input  logic [63:0] in_data,
  input  logic        in_fmt,
  input  logic [1:0]  in_output_fmt,
  output logic [63:0] out_data,
  output logic        out_flg_NV
);

  logic               sgn;
  logic               nan;
  logic [10:0]        exp_f;
  logic [52:0]        mant;
  logic signed [12:0] e;
  logic               big;
  logic [63:0]        m64;
  logic [63:0]        mag;
  logic               ovf;
  logic               pos;
  logic [63:0]        res;

  always_comb begin
    if (in_fmt == FP64) begin
      sgn   = in_data[63];
      exp_f = in_data[62:52];
      mant  = {|in_data[62:52], in_data[51:0]};
      nan   = (&in_data[62:52]) & (|in_data[51:0]);
      e     = $signed({2'b00, exp_f}) - 13'sd1023;
    end else begin
      sgn   = in_data[31];
      exp_f = {3'b000, in_data[30:23]};
      mant  = {|in_data[30:23], in_data[22:0], 29'd0};
      nan   = (&in_data[30:23]) & (|in_data[22:0]);
      e     = $signed({2'b00, exp_f}) - 13'sd127;
    end

    // Integer magnitude only for exponents 0..63; larger is overflow.
    big = (e > 13'sd63);
    m64 = {11'd0, mant};
    mag = '0;
    if (!e[12] && !big) begin
      if (e[5:0] <= 6'd52) mag = m64 >> (6'd52 - e[5:0]);
      else                 mag = m64 << (e[5:0] - 6'd52);
    end

    case (in_output_fmt)
      FMT_S32: ovf = sgn ? (mag > 64'h8000_0000)
                         : (mag > 64'h7FFF_FFFF);
      FMT_U32: ovf = sgn ? (mag != 64'd0)
                         : (mag > 64'hFFFF_FFFF);
      FMT_S64: ovf = sgn ? (mag > 64'h8000_0000_0000_0000)
                         : mag[63];
      default: ovf = sgn & (mag != 64'd0);
    endcase
    ovf = ovf | big | nan;
    pos = ~sgn | nan;

    // 32-bit results are sign-extended into the 64-bit register.
    if (ovf) begin
      case (in_output_fmt)
        FMT_S32: res = pos ? 64'h0000_0000_7FFF_FFFF
                           : 64'hFFFF_FFFF_8000_0000;
        FMT_S64: res = pos ? 64'h7FFF_FFFF_FFFF_FFFF
                           : 64'h8000_0000_0000_0000;
        default: res = pos ? 64'hFFFF_FFFF_FFFF_FFFF
                           : 64'd0;
      endcase
    end else begin
      res = sgn ? (64'd0 - mag) : mag;
      if (!in_output_fmt[1]) res = {{32{res[31]}}, res[31:0]};
    end

    out_data   = res;
    out_flg_NV = ovf;
  end

endmodule

// File: rtl/fp_cvt_sched.sv
// fp_cvt_sched: two-port round-robin scheduler into one FP->int converter,
// with a one-entry result register (EMPTY/FULL) and valid/ready handshakes.
// Ports: ports A/B requests (valid/ready/data/fmt/output_fmt/tag), result
// out_valid/in_ready/out_data/out_flg_NV/out_src/out_tag, in_nv_clr and
// out_nv_sticky. Macro FP_CVT_STICKY_NV_EN compiles in the sticky NV flag.
module fp_cvt_sched
  import fp_cvt_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_a,
  input  logic                  in_valid_b,
  output logic                  out_ready_a,
  output logic                  out_ready_b,
  input  logic [DATA_WIDTH-1:0] in_data_a,
  input  logic [DATA_WIDTH-1:0] in_data_b,
  input  logic                  in_fmt_a,
  input  logic                  in_fmt_b,
  input  logic [1:0]            in_output_fmt_a,
  input  logic [1:0]            in_output_fmt_b,
  input  logic [TAG_W-1:0]      in_tag_a,
  input  logic [TAG_W-1:0]      in_tag_b,
  output logic                  out_valid,
  input  logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_flg_NV,
  output logic                  out_src,
  output logic [TAG_W-1:0]      out_tag,
  input  logic                  in_nv_clr,
  output logic                  out_nv_sticky
);

  state_t                state_q, state_d;
  logic                  rr_q, rr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  nv_q, nv_d;
  src_t                  src_q, src_d;
  logic [TAG_W-1:0]      tag_q, tag_d;

  logic                  load_ok;
  logic                  grant_a;
  logic                  grant_b;
  logic                  accept;
  logic                  drain;
  logic [DATA_WIDTH-1:0] cvt_in;
  logic                  cvt_fmt;
  logic [1:0]            cvt_ofmt;
  logic [DATA_WIDTH-1:0] cvt_data;
  logic                  cvt_nv;

  FP_Int_Convert u_cvt (
    .in_data       (cvt_in),
    .in_fmt        (cvt_fmt),
    .in_output_fmt (cvt_ofmt),
    .out_data      (cvt_data),
    .out_flg_NV    (cvt_nv)
  );

  always_comb begin
    load_ok = (state_q == ST_EMPTY) | in_ready;
    // rr=0 favours A, rr=1 favours B when both request.
    grant_a = in_valid_a & (~in_valid_b | ~rr_q);
    grant_b = in_valid_b & (~in_valid_a | rr_q);
    accept  = load_ok & (grant_a | grant_b);
    drain   = (state_q == ST_FULL) & in_ready;

    cvt_in   = grant_b ? in_data_b       : in_data_a;
    cvt_fmt  = grant_b ? in_fmt_b        : in_fmt_a;
    cvt_ofmt = grant_b ? in_output_fmt_b : in_output_fmt_a;

    state_d = state_q;
    if (accept)     state_d = ST_FULL;
    else if (drain) state_d = ST_EMPTY;

    rr_d   = accept ? grant_a : rr_q;
    data_d = accept ? cvt_data : data_q;
    nv_d   = accept ? cvt_nv : nv_q;
    src_d  = src_q;
    if (accept) src_d = grant_b ? SRC_B : SRC_A;
    tag_d  = accept ? (grant_b ? in_tag_b : in_tag_a) : tag_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      rr_q    <= 1'b0;
      data_q  <= '0;
      nv_q    <= 1'b0;
      src_q   <= SRC_A;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      nv_q    <= nv_d;
      src_q   <= src_d;
      tag_q   <= tag_d;
    end
  end

  assign out_ready_a = load_ok & grant_a;
  assign out_ready_b = load_ok & grant_b;
  assign out_valid   = (state_q == ST_FULL);
  assign out_data    = data_q;
  assign out_flg_NV  = nv_q;
  assign out_src     = src_q;
  assign out_tag     = tag_q;

`ifdef FP_CVT_STICKY_NV_EN
  logic sticky_q, sticky_d;

  // A set wins over a simultaneous clear.
  always_comb begin
    sticky_d = (sticky_q & ~in_nv_clr) | (drain & nv_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign out_nv_sticky = sticky_q;
`else
  logic nv_clr_unused;
  assign nv_clr_unused = in_nv_clr;
  assign out_nv_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_fp_cvt_sched.sv
// Directed self-checking bench for fp_cvt_sched.
// Covers reset, single/dual requests, round-robin, stall, NV and async reset.
module tb_fp_cvt_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_a, in_valid_b;
  logic        out_ready_a, out_ready_b;
  logic [63:0] in_data_a, in_data_b;
  logic        in_fmt_a, in_fmt_b;
  logic [1:0]  in_output_fmt_a, in_output_fmt_b;
  logic [3:0]  in_tag_a, in_tag_b;
  logic        out_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_flg_NV;
  logic        out_src;
  logic [3:0]  out_tag;
  logic        in_nv_clr;
  logic        out_nv_sticky;

  int total = 0;
  int bad   = 0;
  logic exp_sticky;

  always #5 clk = ~clk;

  fp_cvt_sched #(.DATA_WIDTH(64), .TAG_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid_a      (in_valid_a),
    .in_valid_b      (in_valid_b),
    .out_ready_a     (out_ready_a),
    .out_ready_b     (out_ready_b),
    .in_data_a       (in_data_a),
    .in_data_b       (in_data_b),
    .in_fmt_a        (in_fmt_a),
    .in_fmt_b        (in_fmt_b),
    .in_output_fmt_a (in_output_fmt_a),
    .in_output_fmt_b (in_output_fmt_b),
    .in_tag_a        (in_tag_a),
    .in_tag_b        (in_tag_b),
    .out_valid       (out_valid),
    .in_ready        (in_ready),
    .out_data        (out_data),
    .out_flg_NV      (out_flg_NV),
    .out_src         (out_src),
    .out_tag         (out_tag),
    .in_nv_clr       (in_nv_clr),
    .out_nv_sticky   (out_nv_sticky)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid_a = 0; in_valid_b = 0;
    in_data_a = '0; in_data_b = '0;
    in_fmt_a = 0; in_fmt_b = 0;
    in_output_fmt_a = 0; in_output_fmt_b = 0;
    in_tag_a = 0; in_tag_b = 0;
    in_ready = 1; in_nv_clr = 0;
`ifdef FP_CVT_STICKY_NV_EN
    exp_sticky = 1'b1;
`else
    exp_sticky = 1'b0;
`endif

    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_nv", out_flg_NV, 0);
    chk("rst_src", out_src, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_sticky", out_nv_sticky, 0);
    #1 rst = 1'b0;
    cyc();

    // Single A request: FP64 2.0 -> s32
    in_valid_a = 1; in_data_a = 64'h4000_0000_0000_0000;
    in_fmt_a = 1; in_output_fmt_a = 2'b00; in_tag_a = 4'd3;
    #1;
    chk("single_rdy_a", out_ready_a, 1);
    chk("single_rdy_b", out_ready_b, 0);
    cyc();
    in_valid_a = 0;
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 64'd2);
    chk("single_src", out_src, 0);
    chk("single_nv", out_flg_NV, 0);
    chk("single_tag", out_tag, 4'd3);
    cyc();
    chk("single_empty", out_valid, 0);

    // Single B request: FP32 -5.0 -> s32 (sign-extended)
    in_valid_b = 1; in_data_b = 64'h0000_0000_C0A0_0000;
    in_fmt_b = 0; in_output_fmt_b = 2'b00; in_tag_b = 4'd9;
    #1;
    chk("bonly_rdy_a", out_ready_a, 0);
    chk("bonly_rdy_b", out_ready_b, 1);
    cyc();
    in_valid_b = 0;
    chk("bonly_data", out_data, 64'hFFFF_FFFF_FFFF_FFFB);
    chk("bonly_src", out_src, 1);
    chk("bonly_tag", out_tag, 4'd9);
    chk("bonly_nv", out_flg_NV, 0);
    cyc();
    chk("bonly_empty", out_valid, 0);

    // Reset pulse so round-robin restarts at A
    rst = 1; #2 rst = 0;

    // Both ports valid: A 3.0 -> u64, B -5.0 -> s64
    in_valid_a = 1; in_data_a = 64'h4008_0000_0000_0000;
    in_fmt_a = 1; in_output_fmt_a = 2'b11; in_tag_a = 4'd0;
    in_valid_b = 1; in_data_b = 64'h0000_0000_C0A0_0000;
    in_fmt_b = 0; in_output_fmt_b = 2'b10; in_tag_b = 4'd1;
    #1;
    chk("rr_first_a", out_ready_a, 1);
    chk("rr_first_b", out_ready_b, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rr_valid", out_valid, 1);
      chk("rr_src", out_src, i % 2);
      chk("rr_tag", out_tag, i);
      chk("rr_data", out_data,
          (i % 2) ? 64'hFFFF_FFFF_FFFF_FFFB : 64'd3);
      if (i % 2) in_tag_b = in_tag_b + 4'd2;
      else       in_tag_a = in_tag_a + 4'd2;
    end

    // Stall three cycles holding the B result (tag 3)
    in_ready = 0;
    #1;
    chk("stall_rdy_a", out_ready_a, 0);
    chk("stall_rdy_b", out_ready_b, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_valid", out_valid, 1);
      chk("stall_tag", out_tag, 4'd3);
      chk("stall_src", out_src, 1);
      chk("stall_data", out_data, 64'hFFFF_FFFF_FFFF_FFFB);
      chk("stall_rdy_a", out_ready_a, 0);
      chk("stall_rdy_b", out_ready_b, 0);
    end
    in_ready = 1;
    #1;
    chk("release_rdy_a", out_ready_a, 1);
    cyc();
    chk("release_tag_a", out_tag, 4'd4);
    chk("release_src_a", out_src, 0);
    chk("release_data_a", out_data, 64'd3);
    in_tag_a = 4'd6;
    cyc();
    chk("release_tag_b", out_tag, 4'd5);
    chk("release_src_b", out_src, 1);
    chk("release_valid", out_valid, 1);
    in_valid_a = 0; in_valid_b = 0;
    cyc();
    chk("release_empty", out_valid, 0);

    // FP32 1.0e10 -> u32 raises NV
    in_valid_a = 1; in_data_a = 64'h0000_0000_5015_02F9;
    in_fmt_a = 0; in_output_fmt_a = 2'b01; in_tag_a = 4'd7;
    cyc();
    in_valid_a = 0;
    chk("nv_valid", out_valid, 1);
    chk("nv_flag", out_flg_NV, 1);
    chk("nv_tag", out_tag, 4'd7);
    chk("nv_sticky_pre", out_nv_sticky, 0);
    cyc();
    chk("nv_sticky_set", out_nv_sticky, exp_sticky);
    chk("nv_empty", out_valid, 0);
    in_nv_clr = 1;
    cyc();
    in_nv_clr = 0;
    chk("nv_sticky_clr", out_nv_sticky, 0);

    // Async reset while FULL; rr currently points at B
    in_valid_a = 1; in_data_a = 64'h4000_0000_0000_0000;
    in_fmt_a = 1; in_output_fmt_a = 2'b00; in_tag_a = 4'd1;
    in_valid_b = 1; in_data_b = 64'h0000_0000_C0A0_0000;
    in_fmt_b = 0; in_output_fmt_b = 2'b00; in_tag_b = 4'd2;
    cyc();
    chk("ar_pre_valid", out_valid, 1);
    chk("ar_pre_src", out_src, 1);
    #2 rst = 1;
    #1;
    chk("ar_valid_drop", out_valid, 0);
    chk("ar_tag_clr", out_tag, 0);
    #2 rst = 0;
    #1;
    chk("ar_rdy_a", out_ready_a, 1);
    chk("ar_rdy_b", out_ready_b, 0);
    cyc();
    in_valid_a = 0; in_valid_b = 0;
    chk("ar_post_src", out_src, 0);
    chk("ar_post_tag", out_tag, 4'd1);
    chk("ar_post_data", out_data, 64'd2);
    cyc();
    chk("ar_post_empty", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
